// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, hc/vc raster counters,
// polarity-configurable syncs and a valid/ready RGB sink with registered outputs.
module vga_sync_gen #(
  parameter int CD      = 12,
  parameter int CLK_DIV = 4,
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HR      = 96,
  parameter int HB      = 48,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VR      = 2,
  parameter int VB      = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync_clr,
  input  logic [CD-1:0] si_rgb,
  input  logic          si_valid,
  output logic          si_ready,
  input  logic          clr_underflow,
  output logic          underflow,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic [10:0]   hc,
  output logic [10:0]   vc,
  output logic          frame_start,
  output logic          line_start
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(HT - 1);
  localparam logic [10:0]   V_LAST   = 11'(VT - 1);
  localparam logic [10:0]   H_DISP   = 11'(HD);
  localparam logic [10:0]   V_DISP   = 11'(VD);
  localparam logic [10:0]   H_RT_LO  = 11'(HD + HF);
  localparam logic [10:0]   H_RT_HI  = 11'(HD + HF + HR - 1);
  localparam logic [10:0]   V_RT_LO  = 11'(VD + VF);
  localparam logic [10:0]   V_RT_HI  = 11'(VD + VF + VR - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic          h_act;
  logic          v_act;
  logic          video_on;

  // With CLK_DIV=1 the divider is a single bit pinned at 0, so tick is constant 1.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (sync_clr || tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc <= '0;
      vc <= '0;
    end else if (sync_clr) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
      end
    end
  end

  assign h_act    = (hc >= H_RT_LO) && (hc <= H_RT_HI);
  assign v_act    = (vc >= V_RT_LO) && (vc <= V_RT_HI);
  assign video_on = (hc < H_DISP) && (vc < V_DISP);

  // Handshake: si_ready depends only on timing state, never on si_valid, so
  // upstream may drive si_valid from hc/vc without a combinational loop.
  assign si_ready    = tick && video_on;
  assign line_start  = tick && (hc == 11'd0);
  assign frame_start = tick && (hc == 11'd0) && (vc == 11'd0);

  // Syncs and colour are captured on the same tick so they stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      rgb   <= '0;
    end else if (tick) begin
      hsync <= h_act ? H_POL : ~H_POL;
      vsync <= v_act ? V_POL : ~V_POL;
      rgb   <= (video_on && si_valid) ? si_rgb : '0;
    end
  end

  // A starved pixel is shown black; a coincident new underflow beats clr_underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow <= 1'b0;
    end else if (sync_clr) begin
      underflow <= 1'b0;
    end else if (si_ready && !si_valid) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default-timing, small-timing and
// inverted-polarity/divided instances share one clock and reset.
module tb_vga_sync_gen;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        d_sync_clr, d_valid, d_ready, d_clr_uf, d_uf, d_hs, d_vs, d_fs, d_ls;
  logic [11:0] d_si_rgb, d_rgb;
  logic [10:0] d_hc, d_vc;
  // small timing, CLK_DIV=1
  logic        s_sync_clr, s_valid, s_ready, s_clr_uf, s_uf, s_hs, s_vs, s_fs, s_ls;
  logic [11:0] s_si_rgb, s_rgb;
  logic [10:0] s_hc, s_vc;
  // small timing, active-high syncs, CLK_DIV=3
  logic        p_sync_clr, p_valid, p_ready, p_clr_uf, p_uf, p_hs, p_vs, p_fs, p_ls;
  logic [11:0] p_si_rgb, p_rgb;
  logic [10:0] p_hc, p_vc;

  vga_sync_gen dut_def (
    .clk(clk), .reset(reset), .sync_clr(d_sync_clr), .si_rgb(d_si_rgb),
    .si_valid(d_valid), .si_ready(d_ready), .clr_underflow(d_clr_uf),
    .underflow(d_uf), .hsync(d_hs), .vsync(d_vs), .rgb(d_rgb), .hc(d_hc),
    .vc(d_vc), .frame_start(d_fs), .line_start(d_ls)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1)
  ) dut_small (
    .clk(clk), .reset(reset), .sync_clr(s_sync_clr), .si_rgb(s_si_rgb),
    .si_valid(s_valid), .si_ready(s_ready), .clr_underflow(s_clr_uf),
    .underflow(s_uf), .hsync(s_hs), .vsync(s_vs), .rgb(s_rgb), .hc(s_hc),
    .vc(s_vc), .frame_start(s_fs), .line_start(s_ls)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_pol (
    .clk(clk), .reset(reset), .sync_clr(p_sync_clr), .si_rgb(p_si_rgb),
    .si_valid(p_valid), .si_ready(p_ready), .clr_underflow(p_clr_uf),
    .underflow(p_uf), .hsync(p_hs), .vsync(p_vs), .rgb(p_rgb), .hc(p_hc),
    .vc(p_vc), .frame_start(p_fs), .line_start(p_ls)
  );

  typedef struct {
    int n;
    int hc;
    int vc;
    int hs;
    int vs;
    int fs;
    int ls;
    int rdy;
    int rgb;
  } vec_t;

  vec_t tbl[22];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_s_ready(input string name);
    int guard;
    guard = 0;
    while (!s_ready && guard < 300) begin
      step();
      guard++;
    end
    check({name, "_ready_timeout"}, int'(guard >= 300), 0);
  endtask

  initial begin
    int idx;
    int last_fs;
    int xfer[2];
    int p_rdy_cnt;
    int guard;

    // n, hc, vc, hsync, vsync, frame_start, line_start, si_ready, rgb
    tbl = '{
      '{  0,  0, 0, 1, 1, 1, 1, 1,   0},
      '{  1,  1, 0, 1, 1, 0, 0, 1, 100},
      '{  8,  8, 0, 1, 1, 0, 0, 0, 107},
      '{  9,  9, 0, 1, 1, 0, 0, 0,   0},
      '{ 11, 11, 0, 0, 1, 0, 0, 0,   0},
      '{ 12, 12, 0, 0, 1, 0, 0, 0,   0},
      '{ 13, 13, 0, 1, 1, 0, 0, 0,   0},
      '{ 14,  0, 1, 1, 1, 0, 1, 1,   0},
      '{ 15,  1, 1, 1, 1, 0, 0, 1, 114},
      '{ 56,  0, 4, 1, 1, 0, 1, 0,   0},
      '{ 57,  1, 4, 1, 1, 0, 0, 0,   0},
      '{ 70,  0, 5, 1, 1, 0, 1, 0,   0},
      '{ 71,  1, 5, 1, 0, 0, 0, 0,   0},
      '{ 84,  0, 6, 1, 0, 0, 1, 0,   0},
      '{ 85,  1, 6, 1, 1, 0, 0, 0,   0},
      '{ 98,  0, 0, 1, 1, 1, 1, 1,   0},
      '{ 99,  1, 0, 1, 1, 0, 0, 1, 198},
      '{108, 10, 0, 1, 1, 0, 0, 0,   0},
      '{109, 11, 0, 0, 1, 0, 0, 0,   0},
      '{110, 12, 0, 0, 1, 0, 0, 0,   0},
      '{196,  0, 0, 1, 1, 1, 1, 1,   0},
      '{197,  1, 0, 1, 1, 0, 0, 1, 296}
    };

    reset = 1'b0;
    d_sync_clr = 0; d_valid = 1; d_clr_uf = 0; d_si_rgb = 12'hABC;
    s_sync_clr = 0; s_valid = 1; s_clr_uf = 0; s_si_rgb = 12'h0;
    p_sync_clr = 0; p_valid = 1; p_clr_uf = 0; p_si_rgb = 12'h777;

    // reset held across several edges
    repeat (3) step();
    check("rst_d_hc", int'(d_hc), 0);
    check("rst_d_vc", int'(d_vc), 0);
    check("rst_d_hsync", int'(d_hs), 1);
    check("rst_d_vsync", int'(d_vs), 1);
    check("rst_d_rgb", int'(d_rgb), 0);
    check("rst_d_uf", int'(d_uf), 0);
    check("rst_p_hsync", int'(p_hs), 0);
    check("rst_p_vsync", int'(p_vs), 0);

    reset = 1'b1;
    idx = 0;
    last_fs = -1;
    xfer[0] = 0;
    xfer[1] = 0;
    p_rdy_cnt = 0;

    for (int n = 0; n < 300; n++) begin
      // default instance: first tick three edges after release
      case (n)
        0: begin
          check("d0_ready", int'(d_ready), 0);
          check("d0_hsync", int'(d_hs), 1);
          check("d0_vsync", int'(d_vs), 1);
        end
        2: check("d2_ready", int'(d_ready), 0);
        3: begin
          check("d3_ready", int'(d_ready), 1);
          check("d3_fs", int'(d_fs), 1);
          check("d3_hc", int'(d_hc), 0);
          check("d3_rgb", int'(d_rgb), 0);
        end
        4: begin
          check("d4_hc", int'(d_hc), 1);
          check("d4_ready", int'(d_ready), 0);
          check("d4_rgb", int'(d_rgb), 12'hABC);
        end
        default: ;
      endcase

      // small instance vector table
      if (idx < 22 && tbl[idx].n == n) begin
        check($sformatf("s%0d_hc", n), int'(s_hc), tbl[idx].hc);
        check($sformatf("s%0d_vc", n), int'(s_vc), tbl[idx].vc);
        check($sformatf("s%0d_hsync", n), int'(s_hs), tbl[idx].hs);
        check($sformatf("s%0d_vsync", n), int'(s_vs), tbl[idx].vs);
        check($sformatf("s%0d_fs", n), int'(s_fs), tbl[idx].fs);
        check($sformatf("s%0d_ls", n), int'(s_ls), tbl[idx].ls);
        check($sformatf("s%0d_ready", n), int'(s_ready), tbl[idx].rdy);
        check($sformatf("s%0d_rgb", n), int'(s_rgb), tbl[idx].rgb);
        idx++;
      end
      if (n < 196 && s_ready && s_valid) xfer[n / 98]++;
      if (s_fs) begin
        if (last_fs >= 0) check("s_frame_period", n - last_fs, 98);
        last_fs = n;
      end

      // inverted-polarity instance: retrace windows and tick phase
      check($sformatf("p%0d_hsync", n), int'(p_hs), int'((n % 42) >= 33 && (n % 42) <= 38));
      check($sformatf("p%0d_vsync", n), int'(p_vs), int'((n % 294) >= 213 && (n % 294) <= 254));
      check($sformatf("p%0d_ready_phase", n), int'(p_ready && (n % 3 != 2)), 0);
      if (n < 294 && p_ready) p_rdy_cnt++;
      if (n == 2 || n == 5) check($sformatf("p%0d_ready", n), int'(p_ready), 1);

      s_si_rgb = 12'(n + 100);
      step();
    end

    check("s_xfer_frame0", xfer[0], 32);
    check("s_xfer_frame1", xfer[1], 32);
    check("s_last_fs", last_fs, 294);
    check("p_ready_count", p_rdy_cnt, 32);
    check("d_uf_clean", int'(d_uf), 0);

    // starve one active pixel
    wait_s_ready("uf1");
    s_valid = 1'b0;
    s_si_rgb = 12'h5A5;
    step();
    s_valid = 1'b1;
    check("uf_rgb_black", int'(s_rgb), 0);
    check("uf_set", int'(s_uf), 1);
    repeat (3) step();
    check("uf_held", int'(s_uf), 1);
    s_clr_uf = 1'b1;
    step();
    s_clr_uf = 1'b0;
    check("uf_cleared", int'(s_uf), 0);

    // clear coinciding with a fresh underflow: set wins
    wait_s_ready("uf2");
    s_valid = 1'b0;
    s_clr_uf = 1'b1;
    step();
    s_valid = 1'b1;
    s_clr_uf = 1'b0;
    check("uf_set_wins", int'(s_uf), 1);

    // sync_clr at hc=5, vc=2 (tick always high here)
    guard = 0;
    while (!(s_hc == 11'd5 && s_vc == 11'd2) && guard < 300) begin
      step();
      guard++;
    end
    check("clr_pos_timeout", int'(guard >= 300), 0);
    s_sync_clr = 1'b1;
    step();
    s_sync_clr = 1'b0;
    check("clr_hc", int'(s_hc), 0);
    check("clr_vc", int'(s_vc), 0);
    check("clr_uf", int'(s_uf), 0);
    step();
    check("clr_resume_hc", int'(s_hc), 1);

    // mid-line asynchronous reset with live state
    s_si_rgb = 12'h3C3;
    wait_s_ready("rst");
    s_valid = 1'b0;
    step();
    s_valid = 1'b1;
    check("pre_rst_uf", int'(s_uf), 1);
    wait_s_ready("rst2");
    step();
    check("pre_rst_rgb", int'(s_rgb), 12'h3C3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_hc", int'(s_hc), 0);
    check("arst_vc", int'(s_vc), 0);
    check("arst_rgb", int'(s_rgb), 0);
    check("arst_uf", int'(s_uf), 0);
    check("arst_hsync", int'(s_hs), 1);
    check("arst_vsync", int'(s_vs), 1);
    check("arst_p_hsync", int'(p_hs), 0);
    check("arst_d_hc", int'(d_hc), 0);
    repeat (2) step();
    check("arst_hold_hc", int'(s_hc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
